// File: rtl/oneof2_sync_rx_if.sv
// Channel bundle between the dual-rail sender, oneof2_sync_rx and the
// downstream valid/ready consumer.
// The slave modport is the receiver's view. The master modport is the
// environment's view: it drives the rails and out_ready.
interface oneof2_sync_rx_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] r_dr;
    logic               re;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      count;
    logic               err_illegal;

    modport slave (
        input  r_dr,
        input  out_ready,
        output re,
        output out_data,
        output out_valid,
        output count,
        output err_illegal
    );

    modport master (
        output r_dr,
        output out_ready,
        input  re,
        input  out_data,
        input  out_valid,
        input  count,
        input  err_illegal
    );
endinterface

// File: rtl/oneof2_sync_rx.sv
// oneof2_sync_rx: four-phase dual-rail (one-of-2 per bit) receiver.
// The block synchronises every rail into clk, runs the enable handshake
// back to the sender, and queues the decoded words in a FIFO that has a
// valid/ready output.
// Optional feature macro: ONEOF2_RX_ERR_EN. When it is defined, the block
// adds a sticky illegal-codeword flag (both rails of one pair high). When
// it is undefined, err_illegal is tied to 0.
//
// state  | meaning
// S_WAIT | re=0; wait for neutral synced rails and free FIFO space
// S_REQ  | re=1; token requested, wait for a complete codeword
// S_ACK  | re=0; token captured, wait for the rails to return to neutral
module oneof2_sync_rx #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             reset,
    oneof2_sync_rx_if.slave bus
);
    localparam int RW  = 2 * WIDTH;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int PRW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    sync_q [SYNC_STAGES];
    logic [RW-1:0]    s_dr;
    logic [WIDTH-1:0] rail1, rail0;
    logic             complete, neutral, room, push, pop, primed;
    logic [PRW-1:0]   prime_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_after_pop;
    logic             err_q;

    // Per-rail synchroniser chain; the FSM only sees the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.r_dr;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s_dr = sync_q[SYNC_STAGES-1];

    // After reset the chain holds zeros that would look like neutral even while the
    // sender still drives a codeword. This counter waits until the chain has
    // refilled from the real rails, so a stale token is never requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prime_q <= PRW'(SYNC_STAGES);
        else if (prime_q != '0)
            prime_q <= prime_q - PRW'(1);
    end

    assign primed = (prime_q == '0);

    // Split the synced rails into rail1/rail0 vectors.
    always_comb begin
        rail1 = '0;
        rail0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rail1[i] = s_dr[2*i+1];
            rail0[i] = s_dr[2*i];
        end
    end

`ifdef ONEOF2_RX_ERR_EN
    // An illegal 11 pair counts as carrying its rail1 value, so the token still
    // completes once the other pairs arrive.
    assign complete = &(rail1 | rail0);
`else
    assign complete = &(rail1 ^ rail0);
`endif
    assign neutral = primed && (s_dr == '0);

    assign pop             = (count_q != '0) && bus.out_ready;
    assign count_after_pop = count_q - CW'(pop);
    assign room            = (count_after_pop < CW'(DEPTH));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_WAIT;
        else       state_q <= state_d;
    end

    // FSM next state and push strobe.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (neutral && room) state_d = S_REQ;
            end
            S_REQ: begin
                if (complete && (count_q < CW'(DEPTH))) begin
                    push    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (neutral) state_d = room ? S_REQ : S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // FIFO storage; the word comes from rail1 only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= rail1;
        end
    end

    // FIFO pointers and occupancy. DEPTH is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ONEOF2_RX_ERR_EN
    // Sticky flag for a pair seen with both rails high while a token is requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if ((state_q == S_REQ) && |(rail1 & rail0))
            err_q <= 1'b1;
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.re          = (state_q == S_REQ);
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.count       = count_q;
    assign bus.err_illegal = err_q;

endmodule
